// File: rtl/wb_write_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : wb_write_arbiter                                           |
// | Description : Merges pipeline writeback and long-latency results onto    |
// |               the single regfile write port. The pipeline has priority;  |
// |               long-latency results wait in a small circular queue,       |
// |               younger pipeline writes kill older queued writes (WAW),    |
// |               and a starved queue head raises stall_req for a bubble.    |
// |               Optional macro WB_BYPASS_EN: an empty queue with an idle   |
// |               pipeline slot forwards a result straight to the port.      |
// |               rst is asynchronous and active-low.                        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module wb_write_arbiter #(
  parameter int FIFO_DEPTH  = 2,
  parameter int STALL_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_we,
  input  logic [4:0]  wb_waddr,
  input  logic [31:0] wb_wdata,
  input  logic        lu_valid,
  output logic        lu_ready,
  input  logic [4:0]  lu_waddr,
  input  logic [31:0] lu_wdata,
  output logic        we,
  output logic [4:0]  waddr,
  output logic [31:0] wdata,
  output logic        stall_req,
  output logic        pending,
  input  logic [4:0]  qaddr,
  output logic        qhit
);

  localparam int c_PTR_W = $clog2(FIFO_DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;
  localparam int c_STV_W = $clog2(STALL_LIMIT + 1);

  // Queue storage and control
  logic [FIFO_DEPTH-1:0] r_live;
  logic [4:0]            r_addr [FIFO_DEPTH];
  logic [31:0]           r_data [FIFO_DEPTH];
  logic [c_PTR_W-1:0]    r_rptr;
  logic [c_PTR_W-1:0]    r_wptr;
  logic [c_CNT_W-1:0]    r_count;
  logic [c_STV_W-1:0]    r_starve;
  logic                  r_stall;

  logic                  w_wb_act;
  logic                  w_empty;
  logic                  w_head_live;
  logic                  w_pop;
  logic                  w_accept;
  logic                  w_bypass;
  logic                  w_push;
  logic                  w_hit;
  logic [c_STV_W-1:0]    w_starve_nxt;

  // Handshake, push/pop decisions; writes to $0 never occupy a slot
  always_comb begin
    w_wb_act    = wb_we && (wb_waddr != 5'd0);
    w_empty     = (r_count == '0);
    w_head_live = !w_empty && r_live[r_rptr];
    // A dead head always leaves; a live head leaves only when the slot is free
    w_pop       = !w_empty && (!r_live[r_rptr] || !w_wb_act);
    lu_ready    = rst && (r_count < c_CNT_W'(FIFO_DEPTH));
    w_accept    = lu_valid && lu_ready;
    w_bypass    = 1'b0;
`ifdef WB_BYPASS_EN
    w_bypass    = w_empty && !w_wb_act && lu_valid && (lu_waddr != 5'd0);
`endif
    w_push      = w_accept && (lu_waddr != 5'd0) && !w_bypass;
  end

  // Write port selection: pipeline, then live head, then optional bypass
  always_comb begin
    we    = 1'b0;
    waddr = 5'd0;
    wdata = 32'd0;
    if (rst) begin
      if (w_wb_act) begin
        we    = 1'b1;
        waddr = wb_waddr;
        wdata = wb_wdata;
      end else if (w_head_live) begin
        we    = 1'b1;
        waddr = r_addr[r_rptr];
        wdata = r_data[r_rptr];
      end else if (w_bypass) begin
        we    = 1'b1;
        waddr = lu_waddr;
        wdata = lu_wdata;
      end
    end
  end

  // Status: any live entry, and decode interlock lookup
  always_comb begin
    w_hit = 1'b0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (r_live[i] && (r_addr[i] == qaddr)) begin
        w_hit = 1'b1;
      end
    end
    pending = |r_live;
    qhit    = rst && (qaddr != 5'd0) && w_hit;
  end

  // Starvation count: grows only while a live head is blocked, saturating
  always_comb begin
    w_starve_nxt = '0;
    if (w_head_live && !w_pop) begin
      if (r_starve >= c_STV_W'(STALL_LIMIT)) begin
        w_starve_nxt = r_starve;
      end else begin
        w_starve_nxt = r_starve + 1'b1;
      end
    end
  end

  // Queue update: WAW kill first, then pop clear, then push (push is never killed)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_live  <= '0;
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_addr[i] <= 5'd0;
        r_data[i] <= 32'd0;
      end
    end else begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        if (w_wb_act && (r_addr[i] == wb_waddr)) begin
          r_live[i] <= 1'b0;
        end
      end
      if (w_pop) begin
        r_live[r_rptr] <= 1'b0;
        r_rptr         <= r_rptr + 1'b1;
      end
      if (w_push) begin
        r_live[r_wptr] <= 1'b1;
        r_addr[r_wptr] <= lu_waddr;
        r_data[r_wptr] <= lu_wdata;
        r_wptr         <= r_wptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Stall request: set when the blocked head reaches the limit, held until it pops
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_starve <= '0;
      r_stall  <= 1'b0;
    end else begin
      r_starve <= w_starve_nxt;
      if (w_pop) begin
        r_stall <= 1'b0;
      end else if (w_starve_nxt >= c_STV_W'(STALL_LIMIT)) begin
        r_stall <= 1'b1;
      end
    end
  end

  assign stall_req = r_stall;

endmodule
`default_nettype wire

// File: tb/tb_wb_write_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_wb_write_arbiter                                        |
// | Description : Self-checking bench for wb_write_arbiter: directed vector  |
// |               table, hand-written multi-cycle sequences, and random      |
// |               traffic checked against a queue-based reference model.     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_wb_write_arbiter;

  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wb_we = 1'b0;
  logic [4:0]  wb_waddr = '0;
  logic [31:0] wb_wdata = '0;
  logic        lu_valid = 1'b0;
  logic        lu_ready;
  logic [4:0]  lu_waddr = '0;
  logic [31:0] lu_wdata = '0;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        stall_req;
  logic        pending;
  logic [4:0]  qaddr = '0;
  logic        qhit;

  int n_tests = 0;
  int n_fail  = 0;

  wb_write_arbiter #(.FIFO_DEPTH(DEPTH), .STALL_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_waddr(lu_waddr), .lu_wdata(lu_wdata),
    .we(we), .waddr(waddr), .wdata(wdata),
    .stall_req(stall_req), .pending(pending), .qaddr(qaddr), .qhit(qhit)
  );

  always #5 clk = ~clk;

  // ---------------- reference model: a plain queue of pending writes ----------------
  typedef struct {
    bit          live;
    logic [4:0]  addr;
    logic [31:0] data;
  } ent_t;

  ent_t m_q[$];
  int   m_wait;
  bit   m_stall;

  task automatic model_reset();
    m_q.delete();
    m_wait  = 0;
    m_stall = 0;
  endtask

  // Advance the model by one clock using the inputs currently applied
  task automatic model_update();
    bit wbact, rdy, byp, head_live, popped;
    wbact     = wb_we && (wb_waddr != 0);
    rdy       = (m_q.size() < DEPTH);
    byp       = 0;
`ifdef WB_BYPASS_EN
    byp       = (m_q.size() == 0) && !wbact && lu_valid && (lu_waddr != 0);
`endif
    head_live = (m_q.size() > 0) && m_q[0].live;
    popped    = (m_q.size() > 0) && (!m_q[0].live || !wbact);
    if (wbact) begin
      foreach (m_q[i]) if (m_q[i].addr == wb_waddr) m_q[i].live = 0;
    end
    if (popped) void'(m_q.pop_front());
    if (lu_valid && rdy && (lu_waddr != 0) && !byp) m_q.push_back('{1'b1, lu_waddr, lu_wdata});
    if (head_live && !popped) m_wait = (m_wait + 1 > LIMIT) ? LIMIT : m_wait + 1;
    else m_wait = 0;
    if (popped) m_stall = 0;
    else if (m_wait >= LIMIT) m_stall = 1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every output against the model's view of this cycle
  task automatic check_model();
    bit          e_we, e_pend, e_hit, wbact;
    logic [4:0]  e_wa;
    logic [31:0] e_wd;
    wbact = wb_we && (wb_waddr != 0);
    e_we = 0; e_wa = 0; e_wd = 0;
    if (wbact) begin
      e_we = 1; e_wa = wb_waddr; e_wd = wb_wdata;
    end else if (m_q.size() > 0 && m_q[0].live) begin
      e_we = 1; e_wa = m_q[0].addr; e_wd = m_q[0].data;
    end
`ifdef WB_BYPASS_EN
    else if (m_q.size() == 0 && lu_valid && lu_waddr != 0) begin
      e_we = 1; e_wa = lu_waddr; e_wd = lu_wdata;
    end
`endif
    e_pend = 0; e_hit = 0;
    foreach (m_q[i]) begin
      if (m_q[i].live) e_pend = 1;
      if (m_q[i].live && m_q[i].addr == qaddr && qaddr != 0) e_hit = 1;
    end
    chk("we", {31'd0, we}, {31'd0, e_we});
    chk("waddr", {27'd0, waddr}, {27'd0, e_wa});
    chk("wdata", wdata, e_wd);
    chk("lu_ready", {31'd0, lu_ready}, {31'd0, (m_q.size() < DEPTH)});
    chk("pending", {31'd0, pending}, {31'd0, e_pend});
    chk("qhit", {31'd0, qhit}, {31'd0, e_hit});
    chk("stall_req", {31'd0, stall_req}, {31'd0, m_stall});
  endtask

  task automatic drive(input logic wwe, input logic [4:0] wa, input logic [31:0] wd,
                       input logic lv, input logic [4:0] la, input logic [31:0] ld,
                       input logic [4:0] qa);
    wb_we = wwe; wb_waddr = wa; wb_wdata = wd;
    lu_valid = lv; lu_waddr = la; lu_wdata = ld; qaddr = qa;
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  // Push addr 3 and 4 under continuous pipeline writes to addr 7 until stall_req rises
  task automatic fill_and_starve();
    drive(1, 7, 32'h77, 1, 3, 32'h33, 3); #1 check_model(); tick();
    drive(1, 7, 32'h77, 1, 4, 32'h44, 4); #1 check_model(); tick();
    drive(1, 7, 32'h77, 0, 0, 0, 3);      #1 check_model();
    chk("full_ready", {31'd0, lu_ready}, 32'd0);
    chk("full_pending", {31'd0, pending}, 32'd1);
    tick();
    for (int c = 0; c < 2; c++) begin
      drive(1, 7, 32'h77, 0, 0, 0, 3); #1 check_model(); tick();
    end
    chk("stall_rise", {31'd0, stall_req}, 32'd1);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        wbwe;  logic [4:0] wba;  logic [31:0] wbd;
    logic        luv;   logic [4:0] lua;  logic [31:0] lud;
    logic [4:0]  qa;
    logic        ewe;   logic [4:0] ewa;  logic [31:0] ewd;
    logic        erdy;  logic epend;      logic ehit;  logic estall;
  } vec_t;

  vec_t tbl[17];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // basic drain
    tbl[0]  = '{0, 0, 32'h0,      0, 0,  32'h0,        0,  0, 0,  32'h0,        1, 0, 0, 0};
    tbl[1]  = '{0, 0, 32'h0,      1, 5,  32'h12345678, 5,  0, 0,  32'h0,        1, 0, 0, 0};
    tbl[2]  = '{0, 0, 32'h0,      0, 0,  32'h0,        5,  1, 5,  32'h12345678, 1, 1, 1, 0};
    tbl[3]  = '{0, 0, 32'h0,      0, 0,  32'h0,        5,  0, 0,  32'h0,        1, 0, 0, 0};
    // $0 discard
    tbl[4]  = '{0, 0, 32'h0,      1, 0,  32'hDEADBEEF, 0,  0, 0,  32'h0,        1, 0, 0, 0};
    tbl[5]  = '{0, 0, 32'h0,      0, 0,  32'h0,        0,  0, 0,  32'h0,        1, 0, 0, 0};
    // WAW kill
    tbl[6]  = '{0, 0, 32'h0,      1, 9,  32'hAAAA,     9,  0, 0,  32'h0,        1, 0, 0, 0};
    tbl[7]  = '{1, 9, 32'hBBBB,   0, 0,  32'h0,        9,  1, 9,  32'hBBBB,     1, 1, 1, 0};
    tbl[8]  = '{0, 0, 32'h0,      0, 0,  32'h0,        9,  0, 0,  32'h0,        1, 0, 0, 0};
    tbl[9]  = '{0, 0, 32'h0,      0, 0,  32'h0,        9,  0, 0,  32'h0,        1, 0, 0, 0};
    // simultaneous push and pop
    tbl[10] = '{0, 0, 32'h0,      1, 10, 32'h10,       10, 0, 0,  32'h0,        1, 0, 0, 0};
    tbl[11] = '{0, 0, 32'h0,      1, 11, 32'h11,       10, 1, 10, 32'h10,       1, 1, 1, 0};
    tbl[12] = '{0, 0, 32'h0,      0, 0,  32'h0,        10, 1, 11, 32'h11,       1, 1, 0, 0};
    tbl[13] = '{0, 0, 32'h0,      0, 0,  32'h0,        0,  0, 0,  32'h0,        1, 0, 0, 0};
    // pipeline write to $0 leaves the slot to the queue
    tbl[14] = '{0, 0, 32'h0,      1, 12, 32'h12,       12, 0, 0,  32'h0,        1, 0, 0, 0};
    tbl[15] = '{1, 0, 32'hFF,     0, 0,  32'h0,        12, 1, 12, 32'h12,       1, 1, 1, 0};
    tbl[16] = '{0, 0, 32'h0,      0, 0,  32'h0,        12, 0, 0,  32'h0,        1, 0, 0, 0};

    // reset state while rst is held low
    @(negedge clk);
    drive(1, 7, 32'h77, 1, 3, 32'h33, 3);
    #1;
    chk("rst_we", {31'd0, we}, 32'd0);
    chk("rst_ready", {31'd0, lu_ready}, 32'd0);
    chk("rst_pending", {31'd0, pending}, 32'd0);
    chk("rst_stall", {31'd0, stall_req}, 32'd0);
    do_reset();

`ifndef WB_BYPASS_EN
    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].wbwe, tbl[i].wba, tbl[i].wbd, tbl[i].luv, tbl[i].lua, tbl[i].lud, tbl[i].qa);
      #1;
      chk($sformatf("vec%0d_we", i), {31'd0, we}, {31'd0, tbl[i].ewe});
      chk($sformatf("vec%0d_waddr", i), {27'd0, waddr}, {27'd0, tbl[i].ewa});
      chk($sformatf("vec%0d_wdata", i), wdata, tbl[i].ewd);
      chk($sformatf("vec%0d_ready", i), {31'd0, lu_ready}, {31'd0, tbl[i].erdy});
      chk($sformatf("vec%0d_pending", i), {31'd0, pending}, {31'd0, tbl[i].epend});
      chk($sformatf("vec%0d_qhit", i), {31'd0, qhit}, {31'd0, tbl[i].ehit});
      chk($sformatf("vec%0d_stall", i), {31'd0, stall_req}, {31'd0, tbl[i].estall});
      tick();
    end
`endif

    // full queue, starvation, one bubble, then ordered drain
    do_reset();
    fill_and_starve();
    drive(0, 0, 0, 0, 0, 0, 3); #1 check_model();
    chk("bubble_waddr", {27'd0, waddr}, 32'd3);
    chk("bubble_wdata", wdata, 32'h33);
    tick();
    chk("stall_drop", {31'd0, stall_req}, 32'd0);
    drive(1, 7, 32'h77, 0, 0, 0, 4); #1 check_model(); tick();
    drive(0, 0, 0, 0, 0, 0, 4); #1 check_model();
    chk("drain2_waddr", {27'd0, waddr}, 32'd4);
    chk("drain2_wdata", wdata, 32'h44);
    tick();
    #1 check_model();

    // asynchronous reset mid-operation with two entries and stall_req high
    do_reset();
    fill_and_starve();
    drive(1, 7, 32'h77, 1, 8, 32'h88, 3);
    #2 rst = 1'b0;
    #1;
    chk("arst_we", {31'd0, we}, 32'd0);
    chk("arst_waddr", {27'd0, waddr}, 32'd0);
    chk("arst_wdata", wdata, 32'd0);
    chk("arst_ready", {31'd0, lu_ready}, 32'd0);
    chk("arst_stall", {31'd0, stall_req}, 32'd0);
    chk("arst_pending", {31'd0, pending}, 32'd0);
    chk("arst_qhit", {31'd0, qhit}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    drive(0, 0, 0, 0, 0, 0, 3); #1;
    chk("post_rst_ready", {31'd0, lu_ready}, 32'd1);
    chk("post_rst_pending", {31'd0, pending}, 32'd0);
    tick();

    // random traffic against the reference model
    for (int c = 0; c < 3000; c++) begin
      logic wwe;
      wwe = ($urandom_range(0, 99) < 55);
      if (m_stall && $urandom_range(0, 3) != 0) wwe = 0;
      drive(wwe, 5'($urandom_range(0, 7)), $urandom,
            ($urandom_range(0, 99) < 50), 5'($urandom_range(0, 7)), $urandom,
            5'($urandom_range(0, 7)));
      #1 check_model();
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wb_write_arbiter.md
# wb_write_arbiter

Merges register writes from the main pipeline writeback stage and from a long-latency unit (divider / multi-cycle load) onto the single write port of the 32×32 general register file. The main pipeline always has priority. Long-latency results wait in a small queue and drain into idle writeback slots. If a queued result waits too long, the block asks the pipeline to insert a writeback bubble. A query port lets decode interlock on registers that still have a queued write.

## Interface
- `FIFO_DEPTH`, default 2: pending-result queue depth; power of two, ≥2.
- `STALL_LIMIT`, default 4: cycles a queued head may wait before `stall_req` asserts; ≥1.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `wb_we` in 1: pipeline writeback enable. Always accepted; never backpressured.
- `wb_waddr` in 5: pipeline writeback register address.
- `wb_wdata` in 32: pipeline writeback data.
- `lu_valid` in 1: long-latency result valid.
- `lu_ready` out 1: queue can accept a result.
- `lu_waddr` in 5: long-latency destination register.
- `lu_wdata` in 32: long-latency result data.
- `we` out 1: regfile write enable.
- `waddr` out 5: regfile write address.
- `wdata` out 32: regfile write data.
- `stall_req` out 1: request to the pipeline for an empty writeback slot.
- `pending` out 1: the queue holds at least one live entry.
- `qaddr` in 5: decode query address.
- `qhit` out 1: a live queued entry targets `qaddr`.

## Operation
- **Queue structure:** circular buffer of {live, addr, data} entries, with read/write pointers and a count.
- **Accept:** `lu_ready = (count < FIFO_DEPTH)`, based on the registered count only. A push happens when `lu_valid && lu_ready`.
- **Writes to $0:** a result with `lu_waddr == 0` completes the handshake but is discarded, never enqueued.
- **Slot selection, each cycle:**
  1. If `wb_we && wb_waddr != 0`, the port carries the pipeline write.
  2. Else, if the head is live, the port carries the head entry and the head pops.
  3. Else `we = 0`, `waddr = 0`, `wdata = 0`.
- **Dead heads:** an entry at the head with live = 0 pops in any cycle without a write.
- **WAW kill:** a pipeline write to address A clears `live` on every queued entry with addr A. The pipeline write is younger by construction.
  - An entry being pushed in the same cycle is not killed.
- **Simultaneous push and pop:** count is unchanged and both pointers advance. Push when full is impossible by construction.
- **Starvation counter:**
  - Increments each cycle the head is live and does not pop.
  - Clears on a pop or when the queue is empty.
  - When it reaches `STALL_LIMIT`, `stall_req` is set (registered). It stays set until the cycle after the head pops.
- **Status outputs:**
  - `pending` = OR of live bits.
  - `qhit = (qaddr != 0) && (some live entry has addr == qaddr)`; combinational.
- **Pointer wrap:** pointers wrap modulo `FIFO_DEPTH`; count is `log2(FIFO_DEPTH)+1` bits.

## Timing
- **Reset values (while `rst` is low):**
  - Outputs: `we`, `waddr`, `wdata`, `lu_ready`, `stall_req`, `pending`, `qhit` all 0.
  - State: queue empty, all live bits 0, counter 0.
- **Reset mid-operation:** queued results are lost. Issue logic replays them; that is out of scope here.
- **Pipeline write:** combinational pass-through. The regfile captures it on the same rising edge.
- **Queued path latency:** result accepted at edge N, presented on the port during cycle N+1 at the earliest, written at edge N+1.
- **Stall timing:** `stall_req` rises at the edge where the counter reaches `STALL_LIMIT`. The pipeline is required to present `wb_we = 0` from the following cycle until `stall_req` drops.
- **Output decode:** `we`/`waddr`/`wdata` are combinational from registered queue state plus the `wb_*` inputs. `stall_req` is registered.

## Configuration
- **`WB_BYPASS_EN`**
  - Defined:
    - When the queue is empty, the pipeline slot is idle, `lu_valid = 1` and `lu_waddr != 0`, the result goes straight to the port in the same cycle (`we = 1`, `waddr = lu_waddr`, `wdata = lu_wdata`).
    - That result is not enqueued, and `lu_ready` is 1 in that cycle.
  - Undefined: every result is enqueued. Minimum latency from accept to write is one cycle.

## Test plan
- **Basic drain:** push {addr 5, 0x1234_5678} with `wb_we = 0` → `we = 1`, `waddr = 5`, `wdata = 0x1234_5678` the next cycle (same cycle with `WB_BYPASS_EN`). `pending` then drops to 0.
- **Full and drain:** fill the queue with addrs 3 and 4 while `wb_we = 1` to addr 7 every cycle → `lu_ready = 0` and `pending = 1`. `stall_req` rises after 4 waiting cycles. After one bubble, the port writes addr 3, then addr 4 on the next idle slot.
- **WAW kill:** queue {addr 9, 0xAAAA}, then a pipeline write to addr 9 with 0xBBBB → regfile receives only 0xBBBB. The dead head pops with no write, and `qhit` for `qaddr = 9` drops to 0.
- **$0 discard:** `lu_valid` with `lu_waddr = 0` → handshake completes. `pending` stays 0 and `we` stays 0.
- **Simultaneous push and pop:** queue depth 2 holding 1 entry, with push and drain in the same cycle → count stays 1 and the write order is FIFO.
- **Reset mid-operation:** assert `rst` low asynchronously with 2 entries queued and `stall_req` high → all outputs are 0 immediately. After release, `lu_ready = 1` and `pending = 0`.
